// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions used by the bridge and every slave on the bus.
//   ADDR_WAIT    : address of the WAIT configuration register
//   ADDR_ERRCNT  : address of the read-only error counter
//   apb_state_e  : common slave FSM encoding (IDLE, SETUP, WAIT, ACCESS)
//   sat_inc8     : 8-bit increment that sticks at 0xFF
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam logic [7:0] ADDR_WAIT   = 8'h20;
   localparam logic [7:0] ADDR_ERRCNT = 8'h21;
   localparam int         WAIT_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_ACCESS = 2'd3
   } apb_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// -----------------------------------------------------------------------------
// apb_wait_ctr
// 3-bit wait-state down-counter. Loaded on the setup cycle of a transfer and
// decremented once per enabled cycle until it reaches zero, where it holds.
//   clk, rst_n  : clock and synchronous active-low reset
//   load        : load counter with load_value (has priority over enable)
//   load_value  : value to load
//   enable      : decrement request (ignored when already zero)
//   zero        : counter is zero
//   value       : current count, used to see the counter about to expire
// -----------------------------------------------------------------------------
module apb_wait_ctr
   import apb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_value,
   input  logic              enable,
   output logic              zero,
   output logic [WAIT_W-1:0] value
);

   logic [WAIT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero  = (count == '0);
   assign value = count;

endmodule

// File: rtl/apb_wait_slave.sv
// -----------------------------------------------------------------------------
// apb_wait_slave
// APB slave with DEPTH byte registers, a programmable wait-state count and an
// error counter.
//   Address map: 0x00..DEPTH-1 RAM (R/W), 0x20 WAIT (R/W, bits[2:0]),
//                0x21 ERRCNT (RO); everything else is an error.
//   PCLK, PRESETn : clock, synchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : APB request from the bridge
//   PRDATA, PREADY, PSLVERR              : APB response
//
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
// access cycles (PSEL=1, PENABLE=1). The transfer completes, and a write
// commits, at the rising edge where PREADY=1. PSLVERR and PRDATA are only
// meaningful while PREADY=1 and are forced to 0 otherwise. Dropping PSEL
// during wait states abandons the transfer with no side effect.
//
// The register `state` holds IDLE, WAIT or ACCESS. The setup cycle is the
// cycle in which the bus itself shows PSEL=1/PENABLE=0, so it is decoded
// combinationally into `phase`; that lets a zero-wait transfer finish in its
// first access cycle. `phase` is the logical FSM state for debug/checkers.
// -----------------------------------------------------------------------------
module apb_wait_slave
   import apb_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int WAIT_RST = 2
)(
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR
);

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

   // ---------------------------------------------------------------- storage
   logic [7:0]        ram [DEPTH];
   logic [WAIT_W-1:0] wait_reg;
   logic [7:0]        errcnt;

   // ---------------------------------------------------------------- FSM
   apb_state_e state;
   apb_state_e phase;

   logic setup_seen;
   logic access_cyc;

   assign setup_seen = PSEL & ~PENABLE;
   assign access_cyc = PSEL & PENABLE;

   // A setup cycle may follow IDLE or directly follow a completed ACCESS.
   always_comb begin
      phase = state;
      if (setup_seen && ((state == ST_IDLE) || (state == ST_ACCESS))) begin
         phase = ST_SETUP;
      end
   end

   // ---------------------------------------------------------------- counter
   logic              ctr_load;
   logic              ctr_en;
   logic              ctr_zero;
   logic [WAIT_W-1:0] ctr_value;

   assign ctr_load = (phase == ST_SETUP);
   assign ctr_en   = (state == ST_WAIT) && access_cyc;

   apb_wait_ctr u_ctr (
      .clk        (PCLK),
      .rst_n      (PRESETn),
      .load       (ctr_load),
      .load_value (wait_reg),
      .enable     (ctr_en),
      .zero       (ctr_zero),
      .value      (ctr_value)
   );

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state <= ST_IDLE;
      end else begin
         case (phase)
            ST_IDLE:   state <= ST_IDLE;   // PENABLE without setup is ignored
            ST_SETUP:  state <= (wait_reg != '0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT: begin
               if (!PSEL) begin
                  state <= ST_IDLE;        // abort: nothing committed
               end else if (PENABLE && (ctr_value == 3'd1)) begin
                  state <= ST_ACCESS;      // counter reaches zero at this edge
               end
            end
            ST_ACCESS: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- decode
   logic              hit_ram;
   logic              hit_wait;
   logic              hit_errcnt;
   logic              err;
   logic [AW-1:0]     ram_idx;
   logic [7:0]        rd_value;

   assign hit_ram    = ({1'b0, PADDR} < DEPTH_LIM);
   assign hit_wait   = (PADDR == ADDR_WAIT);
   assign hit_errcnt = (PADDR == ADDR_ERRCNT);
   assign err        = ~(hit_ram | hit_wait | hit_errcnt) | (PWRITE & hit_errcnt);
   assign ram_idx    = PADDR[AW-1:0];

   always_comb begin
      rd_value = 8'h00;
      if (hit_ram) begin
         rd_value = ram[ram_idx];
      end else if (hit_wait) begin
         rd_value = {{(8-WAIT_W){1'b0}}, wait_reg};
      end else if (hit_errcnt) begin
         rd_value = errcnt;
      end
   end

   // ---------------------------------------------------------------- response
   assign PREADY  = ((state == ST_WAIT) || (state == ST_ACCESS)) && access_cyc && ctr_zero;
   assign PSLVERR = PREADY & err;
   assign PRDATA  = (PREADY && !PWRITE && !err) ? rd_value : 8'h00;

   // ---------------------------------------------------------------- commit
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            ram[i] <= 8'h00;
         end
         wait_reg <= WAIT_W'(WAIT_RST);
         errcnt   <= 8'h00;
      end else if (PREADY) begin
         if (err) begin
            errcnt <= sat_inc8(errcnt);
         end else if (PWRITE) begin
            if (hit_ram) begin
               ram[ram_idx] <= PWDATA;
            end else if (hit_wait) begin
               wait_reg <= PWDATA[WAIT_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_wait_slave.sv
module tb_apb_wait_slave;
   import apb_pkg::*;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   int tests = 0;
   int fails = 0;

   // reference model
   logic [7:0] m_ram [32];
   int         m_wait;
   int         m_errcnt;

   apb_wait_slave #(.DEPTH(32), .WAIT_RST(2)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_ram[i] = 8'h00;
      m_wait   = 2;
      m_errcnt = 0;
   endtask

   function automatic logic is_err(input logic wr, input logic [7:0] addr);
      logic valid;
      valid = (addr < 8'd32) || (addr == 8'h20) || (addr == 8'h21);
      return !valid || (wr && addr == 8'h21);
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] addr);
      if (addr < 8'd32) return m_ram[addr[4:0]];
      if (addr == 8'h20) return 8'(m_wait);
      if (addr == 8'h21) return 8'(m_errcnt);
      return 8'h00;
   endfunction

   task automatic idle(input int n);
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (n) begin
         @(posedge PCLK); #1;
      end
   endtask

   // Called just after a rising edge; returns just after the completing edge.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data, input string tag);
      int         exp_cyc, cyc;
      logic       exp_err, got_err, stray, done;
      logic [7:0] exp_rd, got_rd;
      exp_err = is_err(wr, addr);
      exp_rd  = (!wr && !exp_err) ? model_read(addr) : 8'h00;
      exp_cyc = m_wait + 1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      cyc = 0; done = 1'b0; stray = 1'b0; got_rd = 8'h00; got_err = 1'b0;
      while (!done && cyc < 16) begin
         @(negedge PCLK);
         cyc++;
         if (PREADY) begin
            done = 1'b1; got_rd = PRDATA; got_err = PSLVERR;
         end else if (PSLVERR !== 1'b0 || PRDATA !== 8'h00) begin
            stray = 1'b1;
         end
         @(posedge PCLK); #1;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      chk({tag, "_cycles"}, cyc, exp_cyc);
      chk({tag, "_pslverr"}, 32'(got_err), 32'(exp_err));
      chk({tag, "_prdata"}, 32'(got_rd), 32'(exp_rd));
      chk({tag, "_quiet_while_waiting"}, 32'(stray), 0);
      if (done) begin
         if (exp_err) begin
            if (m_errcnt < 255) m_errcnt++;
         end else if (wr) begin
            if (addr < 8'd32) m_ram[addr[4:0]] = data;
            else if (addr == 8'h20) m_wait = int'(data[2:0]);
         end
      end
   endtask

   initial begin
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = 8'h00;
      model_reset();
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b1;

      // reset state
      @(negedge PCLK);
      chk("rst_pready", 32'(PREADY), 0);
      chk("rst_pslverr", 32'(PSLVERR), 0);
      chk("rst_prdata", 32'(PRDATA), 0);
      chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
      @(posedge PCLK); #1;

      // default WAIT read: ready on 3rd access cycle, value 2
      xfer(1'b0, 8'h20, 8'h00, "rd_wait_default");

      // zero wait states, back-to-back
      xfer(1'b1, 8'h20, 8'h00, "wr_wait0");
      xfer(1'b1, 8'h05, 8'hA5, "wr_05");
      xfer(1'b0, 8'h05, 8'h00, "rd_05");
      idle(2);

      // maximum wait states; upper WAIT bits ignored
      xfer(1'b1, 8'h20, 8'hFF, "wr_wait7");
      xfer(1'b0, 8'h05, 8'h00, "rd_05_w7");
      xfer(1'b0, 8'h20, 8'h00, "rd_wait7");
      xfer(1'b1, 8'h20, 8'h01, "wr_wait1");

      // error responses
      xfer(1'b1, 8'h40, 8'h11, "err_wr_40");
      xfer(1'b0, 8'h90, 8'h00, "err_rd_90");
      xfer(1'b1, 8'h21, 8'h33, "err_wr_errcnt");
      xfer(1'b0, 8'h21, 8'h00, "rd_errcnt");
      xfer(1'b0, 8'h00, 8'h00, "rd_00_after_err");
      xfer(1'b0, 8'h11, 8'h00, "rd_11_after_err");

      // PENABLE without setup is ignored
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h02; PWDATA = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         chk("noset_pready", 32'(PREADY), 0);
         chk("noset_state", 32'(dut.state), 32'(ST_IDLE));
         @(posedge PCLK); #1;
      end
      idle(1);
      xfer(1'b0, 8'h02, 8'h00, "rd_02_noset");

      // abort during wait states
      xfer(1'b1, 8'h20, 8'h04, "wr_wait4");
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h03; PWDATA = 8'h5A;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge PCLK);
         chk("abort_pready_low", 32'(PREADY), 0);
         @(posedge PCLK); #1;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      chk("abort_state_idle", 32'(dut.state), 32'(ST_IDLE));
      @(posedge PCLK); #1;
      xfer(1'b0, 8'h03, 8'h00, "rd_03_abort");
      xfer(1'b0, 8'h21, 8'h00, "rd_errcnt_abort");

      // reset in the middle of a waited write
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h01; PWDATA = 8'h77;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      chk("midrst_pready_before", 32'(PREADY), 0);
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      @(posedge PCLK); #1;
      @(negedge PCLK);
      chk("midrst_pready_after", 32'(PREADY), 0);
      chk("midrst_state", 32'(dut.state), 32'(ST_IDLE));
      @(posedge PCLK); #1;
      PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
      model_reset();
      @(posedge PCLK); #1;
      xfer(1'b0, 8'h01, 8'h00, "rd_01_midrst");
      xfer(1'b0, 8'h20, 8'h00, "rd_wait_midrst");
      xfer(1'b0, 8'h21, 8'h00, "rd_errcnt_midrst");

      // randomized traffic against the model
      for (int n = 0; n < 120; n++) begin
         logic       wr;
         logic [7:0] addr;
         logic [7:0] data;
         int         sel;
         wr   = 1'($urandom_range(0, 1));
         data = 8'($urandom);
         sel  = $urandom_range(0, 9);
         if (sel < 6)       addr = 8'($urandom_range(0, 31));
         else if (sel == 6) addr = 8'h20;
         else if (sel == 7) addr = 8'h21;
         else               addr = 8'($urandom);
         xfer(wr, addr, data, "rand");
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      // ERRCNT saturation
      xfer(1'b1, 8'h20, 8'h00, "wr_wait0_sat");
      for (int n = 0; n < 260; n++) xfer(1'b0, 8'hC0, 8'h00, "sat_err");
      xfer(1'b0, 8'h21, 8'h00, "rd_errcnt_sat");

      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
